// File: rtl/audio_sample_buffer_pkg.sv
// Shared types and helpers for the audio sample buffer (package audio_pkg).
// The optional peak meter is controlled by AUDIO_SAMPLE_BUFFER_PEAK_METER_EN.
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH = 16;

    typedef logic signed [AUDIO_DATA_WIDTH-1:0] audio_sample_t;

    // Counter increment that holds at all-ones for a counter w bits wide (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/audio_sample_buffer_fifo.sv
// Generic synchronous FIFO: push/pop/flush, combinational head, occupancy count.
// Full/empty come from the count; pointers wrap modulo DEPTH (power of two).
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/audio_sample_buffer.sv
// Sample FIFO between flash fetcher and codec writer with attenuation, underrun/overflow
// counters and an optional peak meter (AUDIO_SAMPLE_BUFFER_PEAK_METER_EN).
module audio_sample_buffer #(
    parameter int AUDIO_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH       = 8,
    parameter int CNT_WIDTH        = 16,
    parameter int PEAK_WINDOW      = 256
) (
    input  logic                              clk_50,
    input  logic                              rst_n,
    input  logic signed [AUDIO_DATA_WIDTH-1:0] audio_data,
    input  logic                              audio_ready,
    input  logic                              flush,
    input  logic                              mute_hold,
    input  logic [2:0]                        volume_shift,
    input  logic                              sample_req,
    output logic signed [AUDIO_DATA_WIDTH-1:0] sample_out,
    output logic                              sample_valid,
    output logic [$clog2(FIFO_DEPTH):0]       fill_level,
    output logic [CNT_WIDTH-1:0]              underrun_cnt,
    output logic [CNT_WIDTH-1:0]              overflow_cnt,
    output logic signed [AUDIO_DATA_WIDTH-1:0] peak_level
);
    import audio_pkg::*;

    localparam int W = AUDIO_DATA_WIDTH;

    function automatic logic signed [W-1:0] sat_abs(input logic signed [W-1:0] v);
        if (v == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
        return (v < 0) ? -v : v;
    endfunction

    logic [W-1:0]        head;
    logic                full;
    logic                empty;
    logic signed [W-1:0] last_sample;
    logic signed [W-1:0] base_p0;
    logic signed [W-1:0] shifted_p0;
    logic signed [W-1:0] served_p1;
    logic                vld_p1;

    sample_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_50),
        .rst_n (rst_n),
        .push  (audio_ready),
        .pop   (sample_req),
        .flush (flush),
        .din   (audio_data),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fill_level)
    );

    always_comb begin
        base_p0 = '0;
        if (!empty)        base_p0 = head;
        else if (mute_hold) base_p0 = last_sample;
        shifted_p0 = base_p0 >>> volume_shift;
    end

    // p0 -> p1: served sample registered one cycle after the request
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            served_p1    <= '0;
            vld_p1       <= 1'b0;
            last_sample  <= '0;
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            vld_p1 <= sample_req;
            if (sample_req) begin
                served_p1 <= shifted_p0;
                if (!empty) last_sample <= head;
                else underrun_cnt <= CNT_WIDTH'(sat_inc(32'(underrun_cnt), CNT_WIDTH));
            end
            if (audio_ready && full && !sample_req && !flush)
                overflow_cnt <= CNT_WIDTH'(sat_inc(32'(overflow_cnt), CNT_WIDTH));
        end
    end

    assign sample_out   = served_p1;
    assign sample_valid = vld_p1;

`ifdef AUDIO_SAMPLE_BUFFER_PEAK_METER_EN
    localparam int WIN_W = $clog2(PEAK_WINDOW + 1);

    logic [WIN_W-1:0]    win_cnt;
    logic signed [W-1:0] run_max;
    logic signed [W-1:0] abs_p0;
    logic signed [W-1:0] new_max;

    always_comb begin
        abs_p0  = sat_abs(shifted_p0);
        new_max = (abs_p0 > run_max) ? abs_p0 : run_max;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt    <= '0;
            run_max    <= '0;
            peak_level <= '0;
        end else if (sample_req) begin
            if (win_cnt == WIN_W'(PEAK_WINDOW - 1)) begin
                peak_level <= new_max;
                run_max    <= '0;
                win_cnt    <= '0;
            end else begin
                run_max <= new_max;
                win_cnt <= win_cnt + 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_peak_window;
    assign unused_peak_window = 32'(PEAK_WINDOW);
    assign peak_level = '0;
`endif

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer; peak checks follow AUDIO_SAMPLE_BUFFER_PEAK_METER_EN.
module tb_audio_sample_buffer;

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic [15:0] audio_data;
    logic        audio_ready;
    logic        flush;
    logic        mute_hold;
    logic [2:0]  volume_shift;
    logic        sample_req;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [3:0]  fill_level;
    logic [15:0] underrun_cnt;
    logic [15:0] overflow_cnt;
    logic [15:0] peak_level;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_peak;

    audio_sample_buffer #(
        .AUDIO_DATA_WIDTH (16),
        .FIFO_DEPTH       (8),
        .CNT_WIDTH        (16),
        .PEAK_WINDOW      (4)
    ) dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .audio_data   (audio_data),
        .audio_ready  (audio_ready),
        .flush        (flush),
        .mute_hold    (mute_hold),
        .volume_shift (volume_shift),
        .sample_req   (sample_req),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .fill_level   (fill_level),
        .underrun_cnt (underrun_cnt),
        .overflow_cnt (overflow_cnt),
        .peak_level   (peak_level)
    );

    always #5 clk_50 = ~clk_50;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        audio_ready = 1'b1;
        audio_data  = v;
        tick();
        audio_ready = 1'b0;
    endtask

    task automatic req(input string tag, input logic [2:0] sh, input logic mh, input logic [15:0] exp);
        sample_req   = 1'b1;
        volume_shift = sh;
        mute_hold    = mh;
        tick();
        sample_req   = 1'b0;
        chk({tag, "_valid"}, 32'(sample_valid), 32'd1);
        chk({tag, "_out"}, 32'(sample_out), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; audio_data = '0; audio_ready = 1'b0; flush = 1'b0;
        mute_hold = 1'b0; volume_shift = '0; sample_req = 1'b0;
        #23;
        chk("rst_out", 32'(sample_out), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_fill", 32'(fill_level), 32'h0);
        chk("rst_under", 32'(underrun_cnt), 32'h0);
        chk("rst_over", 32'(overflow_cnt), 32'h0);
        chk("rst_peak", 32'(peak_level), 32'h0);
        rst_n = 1'b1;
        tick();

        // basic push/pop with latency 1
        push(16'h1234);
        push(16'hF000);
        chk("fill_2", 32'(fill_level), 32'd2);
        req("pop1", 3'd0, 1'b0, 16'h1234);
        chk("fill_1", 32'(fill_level), 32'd1);
        tick();
        chk("valid_drop", 32'(sample_valid), 32'd0);
        chk("out_hold", 32'(sample_out), 32'h1234);
        req("pop2", 3'd0, 1'b0, 16'hF000);
        chk("fill_0", 32'(fill_level), 32'd0);

        // signed attenuation
        push(16'h8000);
        req("shift3", 3'd3, 1'b0, 16'hF000);

        // overflow: 10 pushes into depth 8
        for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
        chk("ovf_fill", 32'(fill_level), 32'd8);
        chk("ovf_cnt", 32'(overflow_cnt), 32'd2);
        for (int i = 0; i < 8; i++) req("ovf_order", 3'd0, 1'b0, 16'h0100 + 16'(i));
        chk("ovf_empty", 32'(fill_level), 32'd0);

        // underrun policy
        push(16'h0400);
        req("last_0400", 3'd0, 1'b0, 16'h0400);
        req("und_hold", 3'd0, 1'b1, 16'h0400);
        req("und_zero", 3'd0, 1'b0, 16'h0000);
        chk("und_cnt", 32'(underrun_cnt), 32'd2);

        // push and pop together while full
        for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i));
        audio_ready = 1'b1;
        audio_data  = 16'h0018;
        req("full_pp", 3'd0, 1'b0, 16'h0010);
        audio_ready = 1'b0;
        chk("full_pp_ovf", 32'(overflow_cnt), 32'd2);
        chk("full_pp_fill", 32'(fill_level), 32'd8);
        for (int i = 1; i < 9; i++) req("full_pp_order", 3'd0, 1'b0, 16'h0010 + 16'(i));

        // flush with push: push discarded, next request underruns
        push(16'h0021); push(16'h0022); push(16'h0023);
        flush = 1'b1; audio_ready = 1'b1; audio_data = 16'h0099;
        tick();
        flush = 1'b0; audio_ready = 1'b0;
        chk("flush_fill", 32'(fill_level), 32'd0);
        chk("flush_ovf", 32'(overflow_cnt), 32'd2);
        req("flush_und", 3'd0, 1'b0, 16'h0000);
        chk("flush_und_cnt", 32'(underrun_cnt), 32'd3);

        // flush with request: head served before clearing
        push(16'h0031); push(16'h0032);
        flush = 1'b1;
        req("flush_req", 3'd0, 1'b0, 16'h0031);
        flush = 1'b0;
        chk("flush_req_fill", 32'(fill_level), 32'd0);
        chk("flush_req_und", 32'(underrun_cnt), 32'd3);
        req("hold_after_flush", 3'd1, 1'b1, 16'h0018);
        chk("und_cnt_4", 32'(underrun_cnt), 32'd4);

        // reset mid-operation
        push(16'h0555); push(16'h0666);
        sample_req = 1'b1; volume_shift = 3'd0;
        tick();
        chk("pre_rst_valid", 32'(sample_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_out", 32'(sample_out), 32'h0);
        chk("mid_rst_fill", 32'(fill_level), 32'd0);
        chk("mid_rst_under", 32'(underrun_cnt), 32'd0);
        sample_req = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();

        // peak meter window of 4
        push(16'd100); push(16'hFED4); push(16'd50); push(16'd7);
        req("pk1", 3'd0, 1'b0, 16'd100);
        req("pk2", 3'd0, 1'b0, 16'hFED4);
        req("pk3", 3'd0, 1'b0, 16'd50);
        chk("peak_mid", 32'(peak_level), 32'd0);
        req("pk4", 3'd0, 1'b0, 16'd7);
`ifdef AUDIO_SAMPLE_BUFFER_PEAK_METER_EN
        exp_peak = 16'd300;
`else
        exp_peak = 16'd0;
`endif
        chk("peak_end", 32'(peak_level), 32'(exp_peak));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_sample_buffer.md
Name: audio_sample_buffer

Overview:
- Sits directly downstream of the flash music fetcher and consumes its audio_data/audio_ready stream in the clk_50 domain.
- Buffers samples in a small FIFO and serves them to the audio codec writer on a request/valid handshake.
- Applies a signed attenuation shift on the way out.
- Decouples the flash-paced fetch timing from codec-paced consumption and reports underrun/overflow.

Parameters:
- AUDIO_DATA_WIDTH, 16, width of one signed PCM sample
- FIFO_DEPTH, 8, number of sample slots; power of two, minimum 2
- CNT_WIDTH, 16, width of the underrun/overflow counters (saturating)
- PEAK_WINDOW, 256, number of served samples per peak-meter window (PEAK_METER_EN only)

Ports:
- clk_50  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- audio_data  in  AUDIO_DATA_WIDTH  sample from fetcher; two's complement
- audio_ready  in  1  one-cycle strobe; audio_data valid this cycle
- flush  in  1  synchronous clear of FIFO contents (direction change/restart)
- mute_hold  in  1  underrun policy: 1 = repeat last served sample, 0 = output zero
- volume_shift  in  3  arithmetic right shift applied to served sample (0 = full scale)
- sample_req  in  1  codec strobe requesting one sample
- sample_out  out  AUDIO_DATA_WIDTH  served, attenuated sample
- sample_valid  out  1  one-cycle strobe; sample_out updated this cycle
- fill_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- underrun_cnt  out  CNT_WIDTH  requests served while empty
- overflow_cnt  out  CNT_WIDTH  samples dropped while full
- peak_level  out  AUDIO_DATA_WIDTH  peak |sample| of last completed window

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: sample_out=0, sample_valid=0, fill_level=0, both counters=0, peak_level=0.
  - Internal: FIFO pointers=0, last-sample register=0.
- Push: audio_ready=1 and FIFO not full -> write audio_data; occupancy +1 at the next edge.
- Overflow: audio_ready=1 with FIFO full and no pop this cycle -> sample dropped; overflow_cnt +1, saturating at all-ones.
- Pop: sample_req=1 -> exactly one cycle later sample_valid=1 with new sample_out. Latency is fixed at 1 cycle regardless of FIFO state.
- Served value:
  - Non-empty: head entry >>> volume_shift, sign-extended. volume_shift is sampled in the same cycle as sample_req. The unshifted head is stored in the last-sample register.
  - Empty (underrun): mute_hold=1 serves last-sample >>> volume_shift; mute_hold=0 serves 0. underrun_cnt +1, saturating.
- Same-cycle push and pop:
  - Both take effect.
  - When full, the pop frees a slot, so the push is accepted and counts no overflow.
  - When empty, the pop is an underrun and the pushed sample is kept; no bypass.
- flush=1:
  - Empties the FIFO at the next edge. Any push in the same cycle is discarded and not counted.
  - A sample_req in the same cycle is still answered with the head as it was before the flush.
  - Counters, last-sample register and peak state are unchanged.
- sample_req held high: one pop per cycle, sample_valid high every cycle.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Full/empty are taken from the occupancy counter.
- Reset asserted mid-operation aborts immediately to reset values; no partial pop is delivered.
- sample_out holds its value between sample_valid strobes.

Optional Feature:
- Macro: AUDIO_SAMPLE_BUFFER_PEAK_METER_EN.
- Defined:
  - Track max |served sample| (after shift) over each PEAK_WINDOW valid strobes.
  - At window end, latch it into peak_level and restart tracking at 0.
  - |-2^(W-1)| saturates to 2^(W-1)-1.
- Undefined: peak_level tied to 0 and no window counter is built.

Decomposition:
- Package audio_pkg holds:
  - AUDIO_DATA_WIDTH constant
  - typedef logic signed [AUDIO_DATA_WIDTH-1:0] audio_sample_t
  - saturating-increment function for counters
- One natural sub-module: sample_fifo. It is a generic synchronous FIFO with push, pop, flush, head, full, empty and count. The top level owns the handshake, attenuation, counters and peak meter.

Test Plan:
- Reset, push 16'h1234 and 16'hF000, then pulse sample_req twice with volume_shift=0 -> sample_valid one cycle after each request; sample_out=16'h1234 then 16'hF000; fill_level 2->1->0.
- Push 16'h8000, request with volume_shift=3 -> sample_out=16'hF000 (sign preserved).
- Push 10 samples into depth 8 without pops -> fill_level=8, overflow_cnt=2, and the first 8 values pop in order.
- Empty FIFO, last served 16'h0400: request with mute_hold=1 -> 16'h0400; request with mute_hold=0 -> 16'h0000; underrun_cnt=2.
- FIFO full, audio_ready and sample_req in the same cycle -> overflow_cnt unchanged, fill_level stays 8, new sample appears 8th in order.
- 3 entries, flush together with audio_ready -> fill_level=0 next cycle; next request is an underrun. With PEAK_METER_EN and PEAK_WINDOW=4, serving 100,-300,50,7 -> peak_level=300 after the 4th strobe.
